// File: rtl/rca_pkg.sv
// -----------------------------------------------------------------------------
// rca_pkg
// Shared constants and types for the ripple-carry adder leaf.
//   RCA_DEFAULT_WIDTH : default operand/sum width.
//   RCA_MAX_WIDTH     : widest legal operand width.
//   rca_max_result_t  : {carry, sum} pair at the widest legal width. Each
//                       adder instance declares its own WIDTH-sized copy.
// Optional feature macro: RCA_ADDER_OVF_EN (consumed by rca_adder).
// -----------------------------------------------------------------------------
package rca_pkg;

  localparam int RCA_DEFAULT_WIDTH = 4;
  localparam int RCA_MAX_WIDTH     = 64;

  typedef struct packed {
    logic                     carry;
    logic [RCA_MAX_WIDTH-1:0] sum;
  } rca_max_result_t;

endpackage : rca_pkg

// File: rtl/rca_full_adder.sv
// -----------------------------------------------------------------------------
// rca_full_adder
// One-bit full adder. This is the building block of the ripple chain.
// Ports:
//   x, y  : operand bits
//   cin   : carry in from the previous bit
//   sum   : x ^ y ^ cin
//   cout  : carry out to the next bit
// The module is purely combinational.
// -----------------------------------------------------------------------------
module rca_full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = x ^ y;
  assign sum  = p ^ cin;
  assign cout = (x & y) | (cin & p);

endmodule : rca_full_adder

// File: rtl/rca_adder.sv
// -----------------------------------------------------------------------------
// rca_adder
// Ripple-carry adder: {co, s} = a + b + ci. The core is a chain of WIDTH
// rca_full_adder instances. The result is registered, so the latency is one
// cycle, and out_valid is registered alongside it.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   in_valid  : a/b/ci are valid this cycle
//   a, b      : unsigned operands, WIDTH bits
//   ci        : carry in
//   out_valid : s/co hold the result of the operand set accepted on the last edge
//   s         : registered sum, WIDTH bits
//   co        : registered carry out
//   ovf       : registered signed overflow, c[WIDTH] ^ c[WIDTH-1]
//               (present only when RCA_ADDER_OVF_EN is defined)
// Parameter: WIDTH, legal range 1..64, default RCA_DEFAULT_WIDTH.
// Optional feature macro: RCA_ADDER_OVF_EN.
// -----------------------------------------------------------------------------
module rca_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef RCA_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
  } rca_result_t;

  // c[i] is the carry into bit i. c[0] is the external carry in.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_w;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    rca_full_adder u_fa (
      .x    (a[i]),
      .y    (b[i]),
      .cin  (c[i]),
      .sum  (sum_w[i]),
      .cout (c[i+1])
    );
  end

  rca_result_t res_d, res_q;
  logic        valid_d, valid_q;

  // When no new operands arrive, the result registers hold their values.
  // Only the valid strobe drops.
  always_comb begin
    res_d   = res_q;
    valid_d = 1'b0;
    if (in_valid) begin
      res_d.carry = c[WIDTH];
      res_d.sum   = sum_w;
      valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign s         = res_q.sum;
  assign co        = res_q.carry;
  assign out_valid = valid_q;

`ifdef RCA_ADDER_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow occurs when the carry into the sign bit differs from the
  // carry out of it. For WIDTH=1, c[0] is ci, so this also covers that case.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule : rca_adder

// File: tb/tb_rca_adder.sv
// -----------------------------------------------------------------------------
// tb_rca_adder
// Self-checking bench for rca_adder. It instantiates a WIDTH=4 adder and a
// WIDTH=8 adder. Each one is compared every cycle against an arithmetic model.
// Hand-computed literal expectations also pin the model at key points.
// Optional feature macro: RCA_ADDER_OVF_EN.
// -----------------------------------------------------------------------------
module tb_rca_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       v4, ci4, ov4, co4;
  logic [3:0] a4, b4, s4;
  logic       v8, ci8, ov8, co8;
  logic [7:0] a8, b8, s8;
`ifdef RCA_ADDER_OVF_EN
  logic       ovf4, ovf8;
`endif

  rca_adder #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v4),
    .a         (a4),
    .b         (b4),
    .ci        (ci4),
    .out_valid (ov4),
    .s         (s4),
    .co        (co4)
`ifdef RCA_ADDER_OVF_EN
    ,
    .ovf       (ovf4)
`endif
  );

  rca_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v8),
    .a         (a8),
    .b         (b8),
    .ci        (ci8),
    .out_valid (ov8),
    .s         (s8),
    .co        (co8)
`ifdef RCA_ADDER_OVF_EN
    ,
    .ovf       (ovf8)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // The model flags signed overflow when the true signed sum falls outside the
  // w-bit two's-complement range.
  function automatic logic ovf_of(input int sum, input int w);
    return (sum > ((1 << (w - 1)) - 1)) || (sum < -(1 << (w - 1)));
  endfunction

  // Model: last accepted result computed as plain integer arithmetic
  logic [4:0] m4 = '0;
  logic       mv4 = 1'b0, mo4 = 1'b0;
  logic [8:0] m8 = '0;
  logic       mv8 = 1'b0, mo8 = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m4 <= '0; mv4 <= 1'b0; mo4 <= 1'b0;
      m8 <= '0; mv8 <= 1'b0; mo8 <= 1'b0;
    end else begin
      if (v4) begin
        m4  <= 5'(int'(a4) + int'(b4) + int'(ci4));
        mo4 <= ovf_of(int'($signed(a4)) + int'($signed(b4)) + int'(ci4), 4);
        mv4 <= 1'b1;
      end else begin
        mv4 <= 1'b0;
      end
      if (v8) begin
        m8  <= 9'(int'(a8) + int'(b8) + int'(ci8));
        mo8 <= ovf_of(int'($signed(a8)) + int'($signed(b8)) + int'(ci8), 8);
        mv8 <= 1'b1;
      end else begin
        mv8 <= 1'b0;
      end
    end
  end

  // Every-cycle compare, sampled on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("w4_result", 64'({ov4, co4, s4}), 64'({mv4, m4}));
      check("w8_result", 64'({ov8, co8, s8}), 64'({mv8, m8}));
`ifdef RCA_ADDER_OVF_EN
      check("w4_ovf", 64'(ovf4), 64'(mo4));
      check("w8_ovf", 64'(ovf8), 64'(mo8));
`endif
    end
  end

  // Drives the WIDTH=4 operands. It also drives a random operand set into the
  // WIDTH=8 adder (valid about 90% of the time), then waits one cycle.
  task automatic apply(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ci);
    v4  = v;
    a4  = a;
    b4  = b;
    ci4 = ci;
    v8  = ($urandom_range(9) != 0);
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    ci8 = 1'($urandom);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_s", 64'(s4), 64'(0));
    check("reset_co_valid", 64'({co4, ov4}), 64'(0));
    check("reset_w8", 64'({ov8, co8, s8}), 64'(0));
    rst_n = 1'b1;

    // Boundaries
    apply(1'b1, 4'hF, 4'h0, 1'b1);
    check("ripple_F_0_1", 64'({co4, s4}), 64'({1'b1, 4'h0}));
    apply(1'b1, 4'hF, 4'hF, 1'b1);
    check("ones_F_F_1", 64'({co4, s4}), 64'({1'b1, 4'hF}));
    apply(1'b1, 4'h0, 4'h0, 1'b0);
    check("zero_0_0_0", 64'({ov4, co4, s4}), 64'({1'b1, 1'b0, 4'h0}));

    // Hold and valid
    apply(1'b1, 4'd3, 4'd4, 1'b0);
    check("hold_load", 64'({ov4, co4, s4}), 64'({1'b1, 1'b0, 4'd7}));
    apply(1'b0, 4'd9, 4'd9, 1'b0);
    check("hold_keep", 64'({ov4, co4, s4}), 64'({1'b0, 1'b0, 4'd7}));

    // Reset mid-stream
    rst_n = 1'b0;
    apply(1'b1, 4'd5, 4'd6, 1'b0);
    check("midreset", 64'({ov4, co4, s4}), 64'(0));
    rst_n = 1'b1;
    apply(1'b1, 4'd1, 4'd1, 1'b1);
    check("after_reset", 64'({ov4, co4, s4}), 64'({1'b1, 1'b0, 4'd3}));

`ifdef RCA_ADDER_OVF_EN
    apply(1'b1, 4'h7, 4'h1, 1'b0);
    check("ovf_7_1", 64'({ovf4, co4, s4}), 64'({1'b1, 1'b0, 4'h8}));
    apply(1'b1, 4'h8, 4'h8, 1'b0);
    check("ovf_8_8", 64'({ovf4, co4, s4}), 64'({1'b1, 1'b1, 4'h0}));
    apply(1'b1, 4'hF, 4'h1, 1'b0);
    check("ovf_F_1", 64'(ovf4), 64'(0));
`endif

    // Exhaustive sweep for WIDTH=4. out_valid must stay high throughout.
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          apply(1'b1, 4'(a), 4'(b), 1'(c));
          if (a == 15 && b == 15 && c == 1)
            check("sweep_last", 64'({ov4, co4, s4}), 64'({1'b1, 1'b1, 4'hF}));
        end

    // Random regression on both adders
    for (int i = 0; i < 1000; i++) begin
      apply(($urandom_range(7) != 0), 4'($urandom), 4'($urandom), 1'($urandom));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_rca_adder

// File: doc/rca_adder.md
Name: rca_adder

Overview:
- Parameterised ripple-carry adder: S = A + B + Ci, with carry-out, built from a chain of 1-bit full adders.
- Result and carry-out are registered (one-cycle latency) with a valid strobe alongside.
- Arithmetic leaf used by the adder/multiplier datapaths.
- Default width is 4 bits.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands a/b/ci are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- ci  input  1  carry-in.
- out_valid  output  1  s/co hold a result.
- s  output  WIDTH  registered sum bits.
- co  output  1  registered carry-out.

Behaviour:
- Combinational core: carry chain c[0] = ci; for bit i, sum[i] = a[i]^b[i]^c[i] and c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); co = c[WIDTH].
- The core is a true ripple chain of full-adder instances. No lookahead and no use of the '+' operator in the core.
- Result identity: {co, s} == a + b + ci, evaluated at WIDTH+1 bits with no truncation.
- Latency: when in_valid=1 at edge N, s/co load the core result at edge N and out_valid=1 after edge N.
- When in_valid=0 at an edge, s/co hold their previous values and out_valid goes to 0.
- Back-to-back operation: a new operand set is accepted every cycle. There is no backpressure and no ready signal.
- Reset: while rst_n=0 at a rising edge, s=0, co=0, out_valid=0, regardless of in_valid.
- Reset during activity: an operation presented in the same cycle as reset is discarded. The first valid result appears one edge after the first in_valid=1 sampled with rst_n=1.
- Boundaries:
  - all-ones + all-ones + 1 gives s = all-ones, co = 1.
  - all-ones + 0 + 1 gives s = 0, co = 1 (full carry ripple).
  - 0 + 0 + 0 gives s = 0, co = 0.
- X-free: the outputs are always driven from flops.

Optional Feature:
- Macro RCA_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (output, 1 bit), registered with the same timing and reset value (0) as co.
  - ovf = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement signed overflow of a + b + ci.
  - For WIDTH=1, ovf = c[1] ^ ci.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package rca_pkg:
  - RCA_DEFAULT_WIDTH = 4.
  - Typedef for the {carry, sum} result pair, parameterised via WIDTH in the module.
- One sub-module: rca_full_adder (inputs x, y, cin; outputs sum, cout; purely combinational). Instantiated WIDTH times with a generate loop.
- No other hierarchy.

Test Plan:
- Exhaustive sweep, WIDTH=4: ci in {0,1}, a and b each 0..15, one set per cycle with in_valid=1 -> every result one cycle later matches {co,s} = a+b+ci. That is 512 checks, zero mismatches, out_valid continuously 1.
- Carry ripple: a=4'hF, b=4'h0, ci=1 -> s=4'h0, co=1. Then a=4'hF, b=4'hF, ci=1 -> s=4'hF, co=1.
- Hold and valid: in_valid=1 with a=3, b=4, ci=0, then in_valid=0 with a=9, b=9 -> s stays 7, co=0, out_valid falls to 0.
- Reset mid-stream: pulse rst_n=0 for one edge while in_valid=1, a=5, b=6 -> s=0, co=0, out_valid=0 after that edge. With the next valid a=1, b=1, ci=1 -> s=3 one edge later.
- RCA_ADDER_OVF_EN, WIDTH=4:
  - a=4'h7, b=4'h1, ci=0 -> s=4'h8, co=0, ovf=1.
  - a=4'h8, b=4'h8, ci=0 -> s=0, co=1, ovf=1.
  - a=4'hF, b=4'h1, ci=0 -> ovf=0.
- WIDTH=8 regression: random 1000 operand sets -> all match a+b+ci at 9 bits.
